// File: rtl/dp_share_scheduler.sv
// Round-robin issue of per-requester operand bundles onto one shared, non-stallable pipelined datapath.
// Latency: grant is combinational, the bundle is on dp_in one cycle later, and res_valid arrives LATENCY+2 cycles after the handshake.
// Backpressure: req_ready is withheld at the per-requester in-flight limit or when en=0; results are never stalled.
module dp_share_scheduler #(
  parameter int N_REQ        = 4,
  parameter int WEIGHT       = 5,
  parameter int WIDTH        = 2,
  parameter int RES_W        = 8,
  parameter int LATENCY      = 11,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*WIDTH-1:0][WEIGHT-1:0] req_data,
  output logic [N_REQ-1:0]                   req_ready,
  output logic                               dp_valid,
  output logic [WIDTH-1:0][WEIGHT-1:0]       dp_in,
  input  logic [RES_W-1:0]                   dp_result,
  output logic [N_REQ-1:0]                   res_valid,
  output logic [RES_W-1:0]                   res_data,
  output logic [N_REQ*CNT_W-1:0]             inflight,
  output logic                               busy
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SEL_W = (N_REQ * WIDTH > 1) ? $clog2(N_REQ * WIDTH) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [IDX_W-1:0]              ptr_q, gnt_idx, cand, ptr_nxt;
  logic                          gnt_vld;
  logic [N_REQ-1:0]              elig, inc, dec;
  logic [CNT_W-1:0]              cnt_q [N_REQ];
  tag_t                          tag_q [LATENCY+1];
  tag_t                          ret_tag;
  logic [SEL_W-1:0]              wsel;
  logic [WIDTH-1:0][WEIGHT-1:0]  gnt_bundle;

  // Stage LATENCY lines up with dp_result for the issue it tracks.
  assign ret_tag = tag_q[LATENCY];
  assign inc     = req_ready;
  assign ptr_nxt = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    elig = '0;
    dec  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && en && (cnt_q[i] < MAX_CNT);
      dec[i]  = ret_tag.vld && (ret_tag.idx == IDX_W'(i));
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_bundle = '0;
    wsel       = '0;
    for (int w = 0; w < WIDTH; w++) begin
      wsel          = SEL_W'(int'(gnt_idx) * WIDTH + w);
      gnt_bundle[w] = req_data[wsel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      dp_valid  <= 1'b0;
      dp_in     <= '0;
      res_valid <= '0;
      res_data  <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      dp_valid <= gnt_vld;
      tag_q[0] <= '{vld: gnt_vld, idx: gnt_idx};
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
      if (gnt_vld) begin
        ptr_q <= ptr_nxt;
        dp_in <= gnt_bundle;
      end
      // Decrement shares the edge that raises res_valid.
      res_valid <= dec;
      if (ret_tag.vld) res_data <= dp_result;
      for (int i = 0; i < N_REQ; i++)
        cnt_q[i] <= cnt_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < N_REQ; i++) inflight[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  always_comb begin
    busy = dp_valid;
    for (int k = 0; k <= LATENCY; k++) busy = busy | tag_q[k].vld;
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt_chk
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(inc[i] && !dec[i] && cnt_q[i] >= MAX_CNT));
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
      !(dec[i] && !inc[i] && cnt_q[i] == '0));
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

endmodule

// File: tb/tb_dp_share_scheduler.sv
// Bench for dp_share_scheduler: issue-list reference model checked every cycle, directed scenarios, random soak.
module tb_dp_share_scheduler;
  localparam int N     = 4;
  localparam int WEIGHT = 5;
  localparam int WIDTH = 2;
  localparam int RES_W = 8;
  localparam int LAT   = 11;
  localparam int MAXI  = 2;
  localparam int CNT_W = 2;
  localparam int HMAX  = 16384;

  typedef logic [WIDTH-1:0][WEIGHT-1:0] bundle_t;
  typedef struct {
    int      t;
    int      r;
    bundle_t b;
  } iss_t;

  logic                         clk = 1'b0;
  logic                         reset, en;
  logic [N-1:0]                 req_valid, req_ready, res_valid;
  logic [N*WIDTH-1:0][WEIGHT-1:0] req_data;
  logic                         dp_valid, busy;
  bundle_t                      dp_in;
  logic [RES_W-1:0]             dp_result, res_data;
  logic [N*CNT_W-1:0]           inflight;

  dp_share_scheduler #(
    .N_REQ(N), .WEIGHT(WEIGHT), .WIDTH(WIDTH), .RES_W(RES_W),
    .LATENCY(LAT), .MAX_INFLIGHT(MAXI), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_valid(dp_valid), .dp_in(dp_in), .dp_result(dp_result),
    .res_valid(res_valid), .res_data(res_data), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: list of issues still owed a result, plus the visible pointer.
  iss_t             pend[$];
  int               ptr;
  bundle_t          last_in;
  bit               last_iss, model_ok, post_rst;
  logic [RES_W-1:0] hist [HMAX];
  int               issued[N], returned[N];

  logic [N-1:0]       obs_ready, obs_res_valid;
  logic [N*CNT_W-1:0] obs_infl;
  logic               obs_dp_valid, obs_busy;
  bundle_t            obs_dp_in;
  logic [RES_W-1:0]   obs_res_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int outstanding(input int r);
    int n = 0;
    foreach (pend[q]) if (pend[q].r == r && pend[q].t + LAT + 2 > cyc) n++;
    return n;
  endfunction

  function automatic int pick();
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (req_valid[j] && en && outstanding(j) < MAXI) return j;
    end
    return -1;
  endfunction

  task automatic model_cycle(input bit r);
    logic [N-1:0]       e_ready, e_res;
    logic [N*CNT_W-1:0] e_infl;
    logic [RES_W-1:0]   e_data;
    bit                 e_busy, has_res;
    bundle_t            b;
    int                 g;
    e_ready = '0; e_res = '0; e_infl = '0; e_data = '0; e_busy = 0; has_res = 0;
    g = pick();
    if (g >= 0) e_ready[g] = 1'b1;
    for (int i = 0; i < N; i++) e_infl[i*CNT_W +: CNT_W] = CNT_W'(outstanding(i));
    foreach (pend[q]) begin
      if (pend[q].t + LAT + 2 == cyc) begin
        e_res[pend[q].r] = 1'b1;
        e_data = hist[(pend[q].t + LAT + 1) % HMAX];
        has_res = 1;
      end
      if (pend[q].t + 1 <= cyc && cyc <= pend[q].t + LAT + 1) e_busy = 1;
    end
    if (model_ok) begin
      chk("req_ready", obs_ready, e_ready);
      chk("res_valid", obs_res_valid, e_res);
      if (has_res) chk("res_data", obs_res_data, e_data);
      if (post_rst) chk("res_data_after_reset", obs_res_data, 0);
      chk("dp_valid", obs_dp_valid, last_iss);
      chk("dp_in", obs_dp_in, last_in);
      chk("inflight", obs_infl, e_infl);
      chk("busy", obs_busy, e_busy);
      for (int i = 0; i < N; i++) if (obs_res_valid[i]) returned[i]++;
    end
    while (pend.size() > 0 && pend[0].t + LAT + 2 <= cyc) void'(pend.pop_front());
    if (r) begin
      pend.delete();
      ptr = 0; last_in = '0; last_iss = 0; model_ok = 1; post_rst = 1;
    end else begin
      post_rst = 0;
      last_iss = (g >= 0);
      if (g >= 0) begin
        for (int w = 0; w < WIDTH; w++) b[w] = req_data[g*WIDTH + w];
        pend.push_back('{t: cyc, r: g, b: b});
        last_in = b;
        ptr = (g + 1) % N;
        issued[g]++;
      end
    end
  endtask

  // Called 1 time unit after a rising edge; drives the cycle, samples mid-cycle, advances to the next cycle.
  task automatic run(input bit r, input bit e, input logic [N-1:0] v);
    reset = r; en = e; req_valid = v;
    for (int k = 0; k < N*WIDTH; k++) req_data[k] = WEIGHT'($urandom);
    dp_result = RES_W'($urandom);
    hist[cyc % HMAX] = dp_result;
    #3;
    obs_ready = req_ready; obs_res_valid = res_valid; obs_infl = inflight;
    obs_dp_valid = dp_valid; obs_busy = busy; obs_dp_in = dp_in; obs_res_data = res_data;
    model_cycle(r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    run(1'b1, 1'b0, '0);
    run(1'b1, 1'b0, '0);
  endtask

  logic [N-1:0]     exp2 [14] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8,
                                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
  bundle_t          b2;
  logic [RES_W-1:0] d12;

  initial begin
    reset = 1'b1; en = 1'b0; req_valid = '0; req_data = '0; dp_result = '0;
    model_ok = 0; post_rst = 0; ptr = 0; last_in = '0; last_iss = 0;
    @(posedge clk);
    #1;

    // Single request from requester 2.
    do_reset();
    run(1'b0, 1'b1, 4'b0100);
    chk("single_grant", obs_ready, 4'b0100);
    for (int w = 0; w < WIDTH; w++) b2[w] = req_data[2*WIDTH + w];
    for (int c = 1; c <= 14; c++) begin
      run(1'b0, 1'b1, '0);
      if (c == 1) begin
        chk("single_dp_valid", obs_dp_valid, 1);
        chk("single_dp_in", obs_dp_in, b2);
      end
      if (c == 1 || c == 12) chk("single_infl_1", obs_infl[2*CNT_W +: CNT_W], 1);
      if (c == 12) d12 = dp_result;
      if (c == 13) begin
        chk("single_res_valid", obs_res_valid, 4'b0100);
        chk("single_res_data", obs_res_data, d12);
        chk("single_infl_0", obs_infl[2*CNT_W +: CNT_W], 0);
      end
    end

    // Fairness with all four requesting.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      run(1'b0, 1'b1, 4'hf);
      chk("fair_grant", obs_ready, exp2[c]);
    end

    // In-flight limit on a single requester.
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      run(1'b0, 1'b1, 4'b0010);
      chk("limit_grant", obs_ready, (c == 0 || c == 1 || c == 13 || c == 14) ? 4'b0010 : 4'b0000);
      if (c == 13) chk("limit_res", obs_res_valid, 4'b0010);
    end

    // Enable gating.
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      run(1'b0, !(c >= 3 && c <= 6), 4'hf);
      if (c >= 3 && c <= 6) chk("en_blocked", obs_ready, 0);
      if (c == 7) chk("en_resume_ptr", obs_ready, 4'b1000);
      if (c == 13) chk("en_res0", obs_res_valid, 4'b0001);
      if (c == 14) chk("en_res1", obs_res_valid, 4'b0010);
      if (c == 15) chk("en_res2", obs_res_valid, 4'b0100);
    end

    // Reset with issues in flight.
    do_reset();
    for (int c = 0; c <= 4; c++) run(1'b0, 1'b1, 4'hf);
    run(1'b0, 1'b1, '0);
    run(1'b1, 1'b0, '0);
    run(1'b0, 1'b1, '0);
    chk("rst_infl", obs_infl, 0);
    chk("rst_busy", obs_busy, 0);
    chk("rst_res", obs_res_valid, 0);
    run(1'b0, 1'b1, 4'hf);
    chk("rst_ptr_grant", obs_ready, 4'b0001);
    for (int c = 9; c <= 21; c++) begin
      run(1'b0, 1'b1, '0);
      chk("rst_res_after", obs_res_valid, (c == 21) ? 4'b0001 : 4'b0000);
    end

    // Random soak.
    do_reset();
    for (int i = 0; i < N; i++) begin issued[i] = 0; returned[i] = 0; end
    for (int c = 0; c < 10000; c++)
      run(1'b0, ($urandom_range(0, 3) != 0), N'($urandom_range(0, 15)));
    for (int c = 0; c < 20; c++) run(1'b0, 1'b1, '0);
    for (int i = 0; i < N; i++) chk("soak_result_count", returned[i], issued[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
